// File: rtl/iot_pkg.sv
// Shared types and constants for the IoT event transmitter.
// No ports; imported by the interface, the picker, the top and the bench.
package iot_pkg;

    localparam int CNT_W     = 8;
    localparam int N_DEV_DEF = 8;
    localparam int ID_W_DEF  = $clog2(N_DEV_DEF);

    // One emitted event as seen by the monitor
    typedef struct packed {
        logic                on_off;
        logic [ID_W_DEF-1:0] dev_id;
    } ev_t;

endpackage

// File: rtl/iot_event_tx_if.sv
// Status-bus / monitor-event bundle for iot_event_tx.
// master: transmitter side (takes dev_status/hold, drives events).
// slave : environment side (drives dev_status/hold, takes events).
// active_cnt exists only when IOT_TX_SHADOW_CNT_EN is defined.
interface iot_event_tx_if
    import iot_pkg::*;
#(
    parameter int N_DEV = N_DEV_DEF,
    parameter int ID_W  = $clog2(N_DEV)
);

    logic [N_DEV-1:0] dev_status;
    logic             hold;
    logic             change;
    logic             on_off;
    logic [ID_W-1:0]  dev_id;
    logic             pending;
`ifdef IOT_TX_SHADOW_CNT_EN
    logic [CNT_W-1:0] active_cnt;

    modport master (
        input  dev_status, hold,
        output change, on_off, dev_id, pending, active_cnt
    );

    modport slave (
        output dev_status, hold,
        input  change, on_off, dev_id, pending, active_cnt
    );
`else
    modport master (
        input  dev_status, hold,
        output change, on_off, dev_id, pending
    );

    modport slave (
        output dev_status, hold,
        input  change, on_off, dev_id, pending
    );
`endif

endinterface

// File: rtl/rr_pick.sv
// Rotate-priority find-first: first set req bit at ptr, ptr+1, ... mod N_DEV.
// in: req[N_DEV], ptr[ID_W]; out: gnt_vld, gnt_idx[ID_W]. Purely combinational.
module rr_pick
    import iot_pkg::*;
#(
    parameter int N_DEV = N_DEV_DEF,
    parameter int ID_W  = $clog2(N_DEV)
) (
    input  logic [N_DEV-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic             gnt_vld,
    output logic [ID_W-1:0]  gnt_idx
);

    int j;

    // Walk farthest-to-nearest so the nearest hit to ptr is written last
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        j       = 0;
        for (int k = N_DEV - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % N_DEV;
            if (req[j]) begin
                gnt_vld = 1'b1;
                gnt_idx = ID_W'(j);
            end
        end
    end

endmodule

// File: rtl/iot_event_tx.sv
// Serialises net per-device on/off changes into one monitor event per cycle.
// Ports: clk, rst (sync, active-high), bus (iot_event_tx_if.master).
// Build option IOT_TX_SHADOW_CNT_EN adds the active_cnt shadow counter.
module iot_event_tx
    import iot_pkg::*;
#(
    parameter int N_DEV = N_DEV_DEF,
    parameter int ID_W  = $clog2(N_DEV)
) (
    input  logic           clk,
    input  logic           rst,
    iot_event_tx_if.master bus
);

    logic [N_DEV-1:0] status_q;
    logic [N_DEV-1:0] sent;
    logic [N_DEV-1:0] sent_nxt;
    logic [N_DEV-1:0] diff;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  rr_nxt;
    logic [ID_W-1:0]  g_idx;
    logic             g_vld;
    logic             fire;

    logic             change_q;
    logic             on_off_q;
    logic [ID_W-1:0]  dev_id_q;
    logic             pending_q;

    // Devices whose sampled level differs from what the monitor was told
    assign diff = status_q ^ sent;

    rr_pick #(
        .N_DEV (N_DEV),
        .ID_W  (ID_W)
    ) u_pick (
        .req     (diff),
        .ptr     (rr_ptr),
        .gnt_vld (g_vld),
        .gnt_idx (g_idx)
    );

    assign fire = g_vld & ~bus.hold;

    assign rr_nxt = (g_idx == ID_W'(N_DEV - 1)) ? '0 : g_idx + ID_W'(1);

    always_comb begin
        sent_nxt = sent;
        if (fire) begin
            sent_nxt[g_idx] = status_q[g_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            status_q  <= '0;
            sent      <= '0;
            rr_ptr    <= '0;
            change_q  <= 1'b0;
            on_off_q  <= 1'b0;
            dev_id_q  <= '0;
            pending_q <= 1'b0;
        end else begin
            status_q  <= bus.dev_status;
            sent      <= sent_nxt;
            // Look-ahead: diff as it will be after this edge
            pending_q <= |(bus.dev_status ^ sent_nxt);
            change_q  <= fire;
            if (fire) begin
                on_off_q <= status_q[g_idx];
                dev_id_q <= g_idx;
                rr_ptr   <= rr_nxt;
            end
        end
    end

    assign bus.change  = change_q;
    assign bus.on_off  = on_off_q;
    assign bus.dev_id  = dev_id_q;
    assign bus.pending = pending_q;

`ifdef IOT_TX_SHADOW_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    // Mirrors the monitor count; wraps both ways like the monitor does
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (fire) begin
            cnt_q <= status_q[g_idx] ? cnt_q + CNT_W'(1)
                                     : cnt_q - CNT_W'(1);
        end
    end

    assign bus.active_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_iot_event_tx.sv
// Scoreboard bench for iot_event_tx: expected events are queued as
// stimulus is applied and popped when the DUT strobes change.
module tb_iot_event_tx;
    import iot_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;
    ev_t  sb[$];

    always #5 clk = ~clk;

    iot_event_tx_if #(.N_DEV(8)) bus ();

    iot_event_tx #(.N_DEV(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(logic on, int id);
        ev_t e;
        e.on_off = on;
        e.dev_id = ID_W_DEF'(id);
        sb.push_back(e);
    endtask

    task automatic drain(string tag);
        for (int i = 0; i < 40 && sb.size() != 0; i++) tick();
        chk({tag, "_drain"}, sb.size(), 0);
    endtask

    task automatic chk_cnt(string tag, int exp);
`ifdef IOT_TX_SHADOW_CNT_EN
        chk(tag, bus.active_cnt, exp);
`endif
    endtask

    // Event monitor: every strobe must match the head of the scoreboard
    always @(negedge clk) begin
        ev_t got;
        ev_t exp;
        if (bus.change === 1'b1) begin
            got.on_off = bus.on_off;
            got.dev_id = bus.dev_id;
            if (sb.size() != 0) begin
                exp = sb.pop_front();
                chk("event", got, exp);
            end else begin
                exp = ~got;
                chk("spurious", got, exp);
            end
        end
    end

    initial begin
        bus.dev_status = 8'hFF;
        bus.hold       = 1'b0;

        // 1: reset with all on, then release
        tick();
        tick();
        chk("rst_change", bus.change, 0);
        chk("rst_pending", bus.pending, 0);
        chk_cnt("rst_cnt", 0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) push(1'b1, i);
        drain("t1");
        tick();
        chk("t1_pending", bus.pending, 0);
        chk_cnt("t1_cnt", 8);

        // go all-off so the next test starts from a known state
        bus.dev_status = 8'h00;
        for (int i = 0; i < 8; i++) push(1'b0, i);
        drain("off");
        chk_cnt("off_cnt", 0);

        // 2: glitch under hold coalesces away
        bus.hold       = 1'b1;
        bus.dev_status = 8'h04;
        tick();
        chk("t2_pend_up", bus.pending, 1);
        bus.dev_status = 8'h00;
        tick();
        chk("t2_pend_dn", bus.pending, 0);
        bus.hold = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2_nochange", bus.change, 0);
        end

        // all on again
        bus.dev_status = 8'hFF;
        for (int i = 0; i < 8; i++) push(1'b1, i);
        drain("on");

        // 3: single disconnect, two-cycle latency
        bus.dev_status = 8'hF7;
        push(1'b0, 3);
        tick();
        chk("t3_early", bus.change, 0);
        tick();
        chk("t3_change", bus.change, 1);
        chk("t3_onoff", bus.on_off, 0);
        chk("t3_id", bus.dev_id, 3);
        chk_cnt("t3_cnt", 7);
        drain("t3");

        // move rr_ptr to 5 by sending device 4
        bus.dev_status = 8'hE7;
        push(1'b0, 4);
        drain("p5");

        // 4: all eight differ, rotation starts at 5
        bus.dev_status = 8'h18;
        for (int k = 0; k < 8; k++) begin
            int id;
            id = (5 + k) % 8;
            push((id == 3) || (id == 4), id);
        end
        tick();
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("t4_b2b", bus.change, 1);
            chk("t4_id", bus.dev_id, (5 + k) % 8);
        end
        tick();
        chk("t4_idle", bus.change, 0);
        chk("t4_pending", bus.pending, 0);
        chk_cnt("t4_cnt", 2);
        drain("t4");

        // 5: hold with diff=81
        bus.hold       = 1'b1;
        bus.dev_status = 8'h99;
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t5_hold_chg", bus.change, 0);
            chk("t5_hold_pend", bus.pending, 1);
        end
        push(1'b1, 7);
        push(1'b1, 0);
        bus.hold = 1'b0;
        tick();
        chk("t5_ev0", bus.change, 1);
        tick();
        chk("t5_ev1", bus.change, 1);
        chk("t5_pend", bus.pending, 0);
        tick();
        chk("t5_idle", bus.change, 0);
        chk_cnt("t5_cnt", 4);
        drain("t5");

        // 6: reset with five events pending
        bus.hold       = 1'b1;
        bus.dev_status = 8'h86;
        tick();
        tick();
        chk("t6_pend", bus.pending, 1);
        rst = 1'b1;
        tick();
        chk("t6_rst_chg", bus.change, 0);
        chk("t6_rst_pend", bus.pending, 0);
        chk_cnt("t6_rst_cnt", 0);
        tick();
        rst      = 1'b0;
        bus.hold = 1'b0;
        push(1'b1, 1);
        push(1'b1, 2);
        push(1'b1, 7);
        drain("t6");
        tick();
        chk("t6_pend_end", bus.pending, 0);
        chk_cnt("t6_cnt", 3);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
